mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MADDR_L, default 32, memory address width.
REQ-002 SHALL have parameter DATA_L, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have IF read port: if_re in 1, if_raddr in MADDR_L, if_rlen in 2, if_rack out 1, if_rdata out DATA_L.
REQ-006 SHALL have MA read port: ma_re in 1, ma_raddr in MADDR_L, ma_rlen in 2, ma_rack out 1, ma_rdata out DATA_L.
REQ-007 SHALL have MA write port: ma_we in 1, ma_waddr in MADDR_L, ma_wlen in 2, ma_wdata in DATA_L, ma_wack out 1.
REQ-008 SHALL have memory port: mem_re out 1, mem_we out 1, mem_addr out MADDR_L, mem_len out 2, mem_wdata out DATA_L, mem_rdata in DATA_L, mem_rack in 1, mem_wack in 1.
REQ-009 SHALL have owner out 2: 00 none, 01 IF, 10 MA read, 11 MA write.

Function
REQ-010 Requests SHALL be level: requester holds re/we and operands stable until its ack pulse.
REQ-011 States SHALL be IDLE, RD, WR, DONE.
REQ-012 In IDLE, on any pending request, SHALL latch the winner's addr/len/wdata, set owner, and assert mem_re (RD) or mem_we (WR) from the next cycle.
REQ-013 MA with ma_we and ma_re both high SHALL be serviced as write first; read arbitrates afresh afterwards.
REQ-014 mem_re/mem_we SHALL stay high until mem_rack/mem_wack is sampled high, then drop in the same edge.
REQ-015 On mem_rack in RD, SHALL register mem_rdata into the owner's rdata output and pulse the owner's rack for exactly one cycle; on mem_wack in WR, pulse ma_wack one cycle.
REQ-016 DONE SHALL last one cycle, ignore all requests (requester drops its line), then return to IDLE with owner=00.
REQ-017 Minimum grant-to-grant spacing: 1 cycle mem access + ack cycle + DONE; a request at IDLE with zero-latency memory gets its ack 2 cycles after being sampled.
REQ-018 if_rdata/ma_rdata SHALL hold their last value until the next read completion for that port.
REQ-019 mem_rack/mem_wack in IDLE or DONE, or of the wrong kind for the state, SHALL be ignored.
REQ-020 Latched operands SHALL not change while in RD/WR, regardless of requester inputs.
REQ-021 At most one requester ack SHALL be high in any cycle; at most one of mem_re/mem_we high.

Reset
REQ-022 On rst high, immediately: state IDLE, owner 00, all mem_*/ack outputs 0, rdata outputs 0, latched addr/len/wdata 0.
REQ-023 Reset mid-transaction SHALL abandon it; no ack is issued afterward for the abandoned request.
REQ-024 First arbitration after reset release SHALL be at the first clk edge with rst low.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous IF and MA requests in IDLE, grant alternates, starting with MA after reset, toggling only when both contend.
REQ-026 Macro ARB_ROUND_ROBIN_EN undefined: MA (write, then read) SHALL always win over IF; IF may starve.

Verification
REQ-027 IF read 0x100 len 11, mem returns 0xDEADBEEF after 3 cycles -> mem_re 3 cycles, mem_addr 0x100, if_rack 1 cycle, if_rdata 0xDEADBEEF.
REQ-028 MA write 0x200 data 0x12345678 len 01, immediate wack -> mem_we 1 cycle, mem_wdata 0x12345678, mem_len 01, ma_wack 1 cycle, owner 11 then 00.
REQ-029 IF and MA read both requested continuously, 4 grants -> without macro: MA,MA,MA,MA; with macro: MA,IF,MA,IF.
REQ-030 ma_we and ma_re both high -> write grant first, then read; ma_wack precedes ma_rack.
REQ-031 rst pulse while mem_re high awaiting rack -> all outputs 0 at once; later mem_rack pulse produces no requester ack.
REQ-032 Spurious mem_wack in IDLE and during RD -> no state change, no acks, mem_re still held in RD.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch read
// requester (IF) and a memory-access requester (MA) that can read or write.
// One transaction at a time: IDLE -> RD/WR -> DONE -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate IF/MA on contention);
// without it MA always wins and IF may starve.
module mem_port_arbiter #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32
) (
    input  logic               clk,
    input  logic               rst,
    // IF read port
    input  logic               if_re,
    input  logic [MADDR_L-1:0] if_raddr,
    input  logic [1:0]         if_rlen,
    output logic               if_rack,
    output logic [DATA_L-1:0]  if_rdata,
    // MA read port
    input  logic               ma_re,
    input  logic [MADDR_L-1:0] ma_raddr,
    input  logic [1:0]         ma_rlen,
    output logic               ma_rack,
    output logic [DATA_L-1:0]  ma_rdata,
    // MA write port
    input  logic               ma_we,
    input  logic [MADDR_L-1:0] ma_waddr,
    input  logic [1:0]         ma_wlen,
    input  logic [DATA_L-1:0]  ma_wdata,
    output logic               ma_wack,
    // memory port
    output logic               mem_re,
    output logic               mem_we,
    output logic [MADDR_L-1:0] mem_addr,
    output logic [1:0]         mem_len,
    output logic [DATA_L-1:0]  mem_wdata,
    input  logic [DATA_L-1:0]  mem_rdata,
    input  logic               mem_rack,
    input  logic               mem_wack,
    // current bus owner
    output logic [1:0]         owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_MAR  = 2'b10;
    localparam logic [1:0] OWN_MAW  = 2'b11;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [MADDR_L-1:0]  addr_q, addr_d;
    logic [1:0]          len_q, len_d;
    logic [DATA_L-1:0]   wdata_q, wdata_d;
    logic                if_rack_q, if_rack_d;
    logic                ma_rack_q, ma_rack_d;
    logic                ma_wack_q, ma_wack_d;
    logic [DATA_L-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_L-1:0]   ma_rdata_q, ma_rdata_d;

    logic                ma_req;
    logic                grant_ma;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q = 0: MA has priority on the next contended grant; 1: IF has it
    logic                rr_q, rr_d;
`endif

    // Arbitration: decide whether MA or IF wins when the bus is idle
    always_comb begin
        ma_req   = ma_we | ma_re;
        grant_ma = ma_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (ma_req && if_re) begin
            grant_ma = ~rr_q;
        end
`endif
    end

    // Next-state and output computation for the transaction FSM
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_re_d   = mem_re_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        if_rack_d  = 1'b0;
        ma_rack_d  = 1'b0;
        ma_wack_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (ma_req || if_re) begin
`ifdef ARB_ROUND_ROBIN_EN
                    // Priority flips only when both requesters contend
                    if (ma_req && if_re) begin
                        rr_d = ~rr_q;
                    end
`endif
                    if (grant_ma) begin
                        // A simultaneous MA write and read is served write first
                        if (ma_we) begin
                            state_d  = WR;
                            owner_d  = OWN_MAW;
                            mem_we_d = 1'b1;
                            addr_d   = ma_waddr;
                            len_d    = ma_wlen;
                            wdata_d  = ma_wdata;
                        end else begin
                            state_d  = RD;
                            owner_d  = OWN_MAR;
                            mem_re_d = 1'b1;
                            addr_d   = ma_raddr;
                            len_d    = ma_rlen;
                        end
                    end else begin
                        state_d  = RD;
                        owner_d  = OWN_IF;
                        mem_re_d = 1'b1;
                        addr_d   = if_raddr;
                        len_d    = if_rlen;
                    end
                end
            end
            RD: begin
                // A write ack here is the wrong kind and is ignored
                if (mem_rack) begin
                    mem_re_d = 1'b0;
                    state_d  = DONE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_rack_d  = 1'b1;
                    end else begin
                        ma_rdata_d = mem_rdata;
                        ma_rack_d  = 1'b1;
                    end
                end
            end
            WR: begin
                if (mem_wack) begin
                    mem_we_d  = 1'b0;
                    ma_wack_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Requester sees its ack this cycle and drops its line
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, latched operands and registered outputs; reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            if_rack_q  <= 1'b0;
            ma_rack_q  <= 1'b0;
            ma_wack_q  <= 1'b0;
            if_rdata_q <= '0;
            ma_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            if_rack_q  <= if_rack_d;
            ma_rack_q  <= ma_rack_d;
            ma_wack_q  <= ma_wack_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer; MA is favoured first after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign if_rack   = if_rack_q;
    assign if_rdata  = if_rdata_q;
    assign ma_rack   = ma_rack_q;
    assign ma_rdata  = ma_rdata_q;
    assign ma_wack   = ma_wack_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_len   = len_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_re;
    logic [31:0] if_raddr;
    logic [1:0]  if_rlen;
    logic        if_rack;
    logic [31:0] if_rdata;
    logic        ma_re;
    logic [31:0] ma_raddr;
    logic [1:0]  ma_rlen;
    logic        ma_rack;
    logic [31:0] ma_rdata;
    logic        ma_we;
    logic [31:0] ma_waddr;
    logic [1:0]  ma_wlen;
    logic [31:0] ma_wdata;
    logic        ma_wack;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rack;
    logic        mem_wack;
    logic [1:0]  owner;

    // memory model: auto mode acks immediately, manual mode is scripted
    logic        auto_mem;
    logic        man_rack;
    logic        man_wack;
    logic [31:0] man_rdata;

    assign mem_rack  = auto_mem ? mem_re : man_rack;
    assign mem_wack  = auto_mem ? mem_we : man_wack;
    assign mem_rdata = auto_mem ? {16'hCAFE, mem_addr[15:0]} : man_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MADDR_L(32), .DATA_L(32)) dut (
        .clk(clk), .rst(rst),
        .if_re(if_re), .if_raddr(if_raddr), .if_rlen(if_rlen),
        .if_rack(if_rack), .if_rdata(if_rdata),
        .ma_re(ma_re), .ma_raddr(ma_raddr), .ma_rlen(ma_rlen),
        .ma_rack(ma_rack), .ma_rdata(ma_rdata),
        .ma_we(ma_we), .ma_waddr(ma_waddr), .ma_wlen(ma_wlen),
        .ma_wdata(ma_wdata), .ma_wack(ma_wack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rack(mem_rack), .mem_wack(mem_wack),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] grants [4];
        logic [1:0] exp_g  [4];
        logic [1:0] prev;
        int         n;
        int         re_cnt;

        rst = 1'b1;
        if_re = 0; if_raddr = 0; if_rlen = 0;
        ma_re = 0; ma_raddr = 0; ma_rlen = 0;
        ma_we = 0; ma_waddr = 0; ma_wlen = 0; ma_wdata = 0;
        auto_mem = 0; man_rack = 0; man_wack = 0; man_rdata = 0;

        // reset state
        step();
        chk("rst_owner", owner, 2'b00);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // IF read, memory answers after three cycles of mem_re
        step();
        if_re = 1; if_raddr = 32'h100; if_rlen = 2'b11;
        step();
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_len", mem_len, 2'b11);
        chk("t1_owner", owner, 2'b01);
        re_cnt = 0;
        if (mem_re) re_cnt++;
        step();
        if (mem_re) re_cnt++;
        step();
        if (mem_re) re_cnt++;
        chk("t1_re_cycles", re_cnt, 3);
        man_rack = 1; man_rdata = 32'hDEADBEEF;
        step();
        chk("t1_mem_re_drop", mem_re, 1'b0);
        chk("t1_if_rack", if_rack, 1'b1);
        chk("t1_ma_rack", ma_rack, 1'b0);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        if_re = 0; man_rack = 0; man_rdata = 0;
        step();
        chk("t1_if_rack_pulse", if_rack, 1'b0);
        chk("t1_owner_idle", owner, 2'b00);
        chk("t1_if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // MA write with immediate wack
        ma_we = 1; ma_waddr = 32'h200; ma_wlen = 2'b01; ma_wdata = 32'h12345678;
        man_wack = 1;
        step();
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t2_mem_len", mem_len, 2'b01);
        chk("t2_mem_addr", mem_addr, 32'h200);
        chk("t2_owner", owner, 2'b11);
        step();
        chk("t2_mem_we_drop", mem_we, 1'b0);
        chk("t2_ma_wack", ma_wack, 1'b1);
        ma_we = 0; man_wack = 0;
        step();
        chk("t2_ma_wack_pulse", ma_wack, 1'b0);
        chk("t2_owner_idle", owner, 2'b00);

        // MA write and read together: write served first
        auto_mem = 1;
        ma_we = 1; ma_waddr = 32'h304; ma_wdata = 32'hA5A5A5A5; ma_wlen = 2'b10;
        ma_re = 1; ma_raddr = 32'h300; ma_rlen = 2'b10;
        step();
        chk("t3_first_owner", owner, 2'b11);
        step();
        chk("t3_wack", ma_wack, 1'b1);
        chk("t3_no_rack_yet", ma_rack, 1'b0);
        ma_we = 0;
        step();
        chk("t3_idle", owner, 2'b00);
        step();
        chk("t3_read_owner", owner, 2'b10);
        chk("t3_read_addr", mem_addr, 32'h300);
        step();
        chk("t3_rack", ma_rack, 1'b1);
        chk("t3_rdata", ma_rdata, 32'hCAFE0300);
        chk("t3_if_rdata_hold", if_rdata, 32'hDEADBEEF);
        ma_re = 0;
        step();

        // IF and MA read contending continuously, four grants
        if_re = 1; if_raddr = 32'h600; if_rlen = 2'b00;
        ma_re = 1; ma_raddr = 32'h700; ma_rlen = 2'b00;
        prev = 2'b00;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            chk("t4_re_we_excl", {31'd0, mem_re & mem_we}, 1'b0);
            chk("t4_ack_onehot", {31'd0, ($countones({if_rack, ma_rack, ma_wack}) > 1)}, 1'b0);
            if (owner != 2'b00 && prev == 2'b00) begin
                grants[n] = owner;
                n++;
            end
            prev = owner;
        end
        chk("t4_grant_count", n, 4);
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_grant%0d", i), grants[i], exp_g[i]);
        end
        if_re = 0; ma_re = 0;
        repeat (4) step();
        chk("t4_idle", owner, 2'b00);
        auto_mem = 0;

        // reset while awaiting rack
        if_re = 1; if_raddr = 32'h400; if_rlen = 2'b10;
        step();
        chk("t5_mem_re", mem_re, 1'b1);
        #2;
        rst = 1; if_re = 0;
        #1;
        chk("t5_rst_mem_re", mem_re, 1'b0);
        chk("t5_rst_owner", owner, 2'b00);
        chk("t5_rst_addr", mem_addr, 32'h0);
        chk("t5_rst_if_rdata", if_rdata, 32'h0);
        chk("t5_rst_ma_rdata", ma_rdata, 32'h0);
        #1;
        rst = 0;
        man_rack = 1; man_rdata = 32'h0BADF00D;
        step();
        chk("t5_no_if_rack_a", if_rack, 1'b0);
        step();
        chk("t5_no_if_rack_b", if_rack, 1'b0);
        chk("t5_no_ma_rack", ma_rack, 1'b0);
        chk("t5_owner", owner, 2'b00);
        chk("t5_if_rdata", if_rdata, 32'h0);
        man_rack = 0;

        // spurious wack in IDLE and during RD
        man_wack = 1;
        step();
        chk("t6_idle_owner", owner, 2'b00);
        chk("t6_idle_wack", ma_wack, 1'b0);
        chk("t6_idle_we", mem_we, 1'b0);
        if_re = 1; if_raddr = 32'h500; if_rlen = 2'b01;
        step();
        chk("t6_rd_re", mem_re, 1'b1);
        step();
        chk("t6_rd_re_held", mem_re, 1'b1);
        chk("t6_rd_owner", owner, 2'b01);
        chk("t6_rd_no_wack", ma_wack, 1'b0);
        chk("t6_rd_no_rack", if_rack, 1'b0);
        man_wack = 0; man_rack = 1; man_rdata = 32'h55AA55AA;
        step();
        chk("t6_if_rack", if_rack, 1'b1);
        chk("t6_if_rdata", if_rdata, 32'h55AA55AA);
        if_re = 0; man_rack = 0;
        step();
        chk("t6_idle_end", owner, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
